mode_arbiter: RTL

Registered arbiter between the manual, semi-auto and auto drive controllers and the single UART command link to the simulator. It grants one controller ownership of `state`/`moving_state` according to `global_state` and power. Every mode change is sequenced as stop, flush, settle, hand over. It also schedules command-frame transmission: on change, on beacon request, and on a periodic refresh.

---
 rtl/mode_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mode_arbiter.sv
// mode_arbiter: grants one drive controller the state outputs and schedules UART command frames
module mode_arbiter #(
    parameter int SETTLE_CYCLES  = 1000000,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] state_m,
    input  logic [1:0] state_s,
    input  logic [1:0] state_a,
    input  logic [3:0] moving_m,
    input  logic [3:0] moving_s,
    input  logic [3:0] moving_a,
    input  logic       pl_beacon_req,
    input  logic       de_beacon_req,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic [1:0] owner,
    output logic       switching
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_CYCLES);
    typedef enum logic [1:0] {OFF, RUN, DRAIN, SETTLE} st_t;
    st_t st, st_nx;
    logic [1:0] mode, tgt, tgt_nx, owner_nx, sel_state;
    logic [3:0] sel_moving, last;
    logic [SW-1:0] scnt, scnt_nx;
    logic [RW-1:0] rcnt;
    logic pl_pend, de_pend, pl_req, de_req, drained, fire, trig, load, grant;
    assign mode = global_state == 2'b00 ? 2'b00 : global_state == 2'b11 ? 2'b11 : 2'b01;
    assign fire = tx_valid & tx_ready;
    assign switching = st == DRAIN || st == SETTLE;
    assign pl_req = pl_beacon_req && st == RUN && owner == 2'b11;
    assign de_req = de_beacon_req && st == RUN && owner == 2'b11;
    assign trig = moving_state != last || pl_pend || de_pend || pl_req || de_req
                  || rcnt == RW'(REFRESH_CYCLES - 1);
    assign load = st != OFF && !tx_valid && trig;
    assign grant = st_nx == RUN && st != SETTLE;
    assign sel_state = owner_nx == 2'b00 ? state_m : owner_nx == 2'b11 ? state_a : state_s;
    assign sel_moving = owner_nx == 2'b00 ? moving_m : owner_nx == 2'b11 ? moving_a : moving_s;

    // next-state: stop, flush, settle, hand over; power loss wins everywhere
    always_comb begin
        st_nx = st;
        owner_nx = owner;
        tgt_nx = tgt;
        scnt_nx = scnt;
        if (!power) begin
            st_nx = OFF;
            owner_nx = 2'b10;
        end else if (st == OFF) begin
            st_nx = RUN;
            owner_nx = mode;
        end else if (st == RUN) begin
            if (mode != owner) begin
                st_nx = DRAIN;
                tgt_nx = mode;
            end
        end else if (st == DRAIN) begin
            tgt_nx = mode;
            if (fire && drained && tx_data[3:0] == 4'b0000) begin
                st_nx = SETTLE;
                scnt_nx = '0;
            end
        end else if (mode != tgt) begin
            tgt_nx = mode;
            scnt_nx = '0;
        end else if (scnt == SW'(SETTLE_CYCLES - 1)) begin
            st_nx = RUN;
            owner_nx = tgt;
        end else begin
            scnt_nx = scnt + 1'b1;
        end
    end

    // FSM state, ownership and granted outputs (forced to zero unless granting)
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st <= OFF;
            owner <= 2'b10;
            tgt <= 2'b00;
            scnt <= '0;
            state <= 2'b00;
            moving_state <= 4'b0000;
        end else begin
            st <= st_nx;
            owner <= owner_nx;
            tgt <= tgt_nx;
            scnt <= scnt_nx;
            state <= grant ? sel_state : 2'b00;
            moving_state <= grant ? sel_moving : 4'b0000;
        end
    end

    // frame scheduler: load on trigger when idle, hold until accepted, track refresh and drain
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data <= 8'h80;
            last <= 4'b0000;
            pl_pend <= 1'b0;
            de_pend <= 1'b0;
            rcnt <= '0;
            drained <= 1'b0;
        end else begin
            tx_valid <= load | (tx_valid & ~tx_ready);
            if (load)
                tx_data <= {2'b10, de_pend | de_req, pl_pend | pl_req, moving_state};
            if (fire)
                last <= tx_data[3:0];
            pl_pend <= st == OFF || load ? 1'b0 : pl_pend | pl_req;
            de_pend <= st == OFF || load ? 1'b0 : de_pend | de_req;
            rcnt <= fire ? '0 : st != OFF && !tx_valid && rcnt != RW'(REFRESH_CYCLES - 1) ? rcnt + 1'b1 : rcnt;
            drained <= st == DRAIN && (drained | load);
        end
    end
endmodule
